// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence store: colour codes, FSM states, LFSR mask.
package simon_pkg;

  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_YELLOW = 2'd1;
  localparam logic [1:0] COL_BLUE   = 2'd2;
  localparam logic [1:0] COL_RED    = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_FILL = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // One-hot layout matches the compare lines: [3]=green, [2]=yellow, [1]=blue, [0]=red.
  function automatic logic [3:0] color_to_oh(input logic [1:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    case (code)
      COL_GREEN:  oh = 4'b1000;
      COL_YELLOW: oh = 4'b0100;
      COL_BLUE:   oh = 4'b0010;
      COL_RED:    oh = 4'b0001;
      default:    oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR; advances on every clock edge.
module simon_lfsr16 import simon_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] state
);

  // An all-zero state would lock up, so a zero seed is replaced.
  localparam logic [15:0] SeedSafe = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr_q <= SeedSafe;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/simon_seq_store.sv
// Simon colour sequence generator/store with registered indexed read-back.
// Optional SIMON_SEQ_NO_REPEAT_EN: bump a colour that would repeat the previous entry.
module simon_seq_store import simon_pkg::*; #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  GEN_REQ,
  output logic                  GEN_DONE,
  output logic                  BUSY,
  input  logic [DEPTH_LOG2-1:0] RD_IDX,
  output logic [3:0]            COLOR_OH,
  output logic [1:0]            COLOR_CODE
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LastIdx = {DEPTH_LOG2{1'b1}};

  seq_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]            mem_q [Depth];
  logic [15:0]           lfsr_state;
  logic [1:0]            new_color;
  logic [1:0]            wr_color;
  logic                  wr_en;
  logic                  fill_start;
  logic [3:0]            color_oh_q;
  logic [1:0]            color_code_q;
  logic                  unused_lfsr;

  simon_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .state (lfsr_state)
  );

  assign new_color   = lfsr_state[1:0];
  assign unused_lfsr = ^lfsr_state[15:2];

`ifdef SIMON_SEQ_NO_REPEAT_EN
  logic [1:0] prev_q;

  assign wr_color = (new_color == prev_q) ? new_color + 2'd1 : new_color;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= COL_GREEN;
    end else if (fill_start) begin
      prev_q <= COL_GREEN;
    end else if (wr_en) begin
      prev_q <= wr_color;
    end
  end
`else
  assign wr_color = new_color;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    fill_start = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (GEN_REQ) begin
          state_d    = SEQ_FILL;
          cnt_d      = '0;
          fill_start = 1'b1;
        end
      end
      SEQ_FILL: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  assign GEN_DONE = (state_q == SEQ_DONE);
  assign BUSY     = (state_q != SEQ_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory is flop-based so reset can clear every entry asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= COL_GREEN;
      end
    end else if (wr_en) begin
      mem_q[cnt_q] <= wr_color;
    end
  end

  // Read samples pre-write contents, so a same-index write shows up a cycle later.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      color_oh_q   <= 4'b0000;
      color_code_q <= COL_GREEN;
    end else begin
      color_oh_q   <= color_to_oh(mem_q[RD_IDX]);
      color_code_q <= mem_q[RD_IDX];
    end
  end

  assign COLOR_OH   = color_oh_q;
  assign COLOR_CODE = color_code_q;

endmodule

// File: doc/simon_seq_store.md
Name: simon_seq_store

Overview:
- Generates and stores the Simon colour sequence; the game FSM reads it back by index during display and input phases.
- Sits beside the game FSM:
  - Its GEN_REQ/GEN_DONE pair is the FSM's rand request / rand_done handshake.
  - RD_IDX is driven by the I counter.
  - COLOR_OH feeds the yello/re/blu/gree compare lines.
- Colours come from a free-running LFSR, so player timing perturbs each game.

Parameters:
- DEPTH_LOG2, 4: sequence memory holds 2**DEPTH_LOG2 entries (16); this is also the maximum game length.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- GEN_REQ  in  1  level/pulse; sampled only in IDLE; starts a fill of all entries.
- GEN_DONE  out  1  one-cycle pulse when the fill completes.
- BUSY  out  1  high in FILL and DONE.
- RD_IDX  in  DEPTH_LOG2  read index (from the I counter).
- COLOR_OH  out  4  registered one-hot colour of entry RD_IDX: [3]=green, [2]=yellow, [1]=blue, [0]=red.
- COLOR_CODE  out  2  registered binary colour: 00 green, 01 yellow, 10 blue, 11 red.

Behaviour:
- Reset: the following apply immediately, asynchronously.
  - State = IDLE; GEN_DONE=0; BUSY=0.
  - COLOR_OH=4'b0000; COLOR_CODE=2'b00.
  - LFSR=SEED; all memory entries cleared to 00; fill counter = 0; prev colour = 00.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Shifts right every clock in every state, including IDLE.
  - New colour = lfsr[1:0] as sampled at the write edge.
- FSM, three states, binary encoded:
  - IDLE: GEN_REQ=1 at an edge -> FILL, counter cleared to 0.
  - FILL: each edge writes mem[counter] = new colour, records prev colour, and increments counter.
    - When the write targets index 2**DEPTH_LOG2-1 -> DONE (counter wraps to 0).
    - Fill takes exactly 2**DEPTH_LOG2 cycles.
  - DONE: GEN_DONE=1 for exactly this one cycle -> IDLE unconditionally.
  - GEN_DONE is therefore high during cycle DEPTH+1 after the GEN_REQ sample edge (cycle 17 for the default).
- GEN_REQ rules:
  - Ignored in FILL and DONE; requests are not queued.
  - If still high on return to IDLE, a new fill starts on the next edge.
- Read path:
  - COLOR_OH/COLOR_CODE update on every edge from mem[RD_IDX]: 1-cycle latency, in all states.
  - Read and write to the same index on the same edge returns the old contents.
  - COLOR_OH is always exactly one-hot after the first post-reset edge. Cleared memory reads as green (4'b1000).
- RESET mid-FILL: fill aborts; memory is cleared; GEN_DONE is not pulsed; LFSR returns to SEED.
- RESET has priority over every other input.
- Out-of-range RD_IDX cannot occur, since the width exactly matches the depth.

Optional Feature:
- Macro: SIMON_SEQ_NO_REPEAT_EN.
- Defined: during FILL, if the new colour equals the previously written colour, store (new colour + 1) mod 4 instead.
  - The result is that consecutive entries never repeat.
  - Entry 0 compares against prev colour = 00, which is reset and re-cleared at each fill start.
- Undefined: raw lfsr[1:0] is stored; repeats are allowed.
- The prev-colour register is not present when the macro is undefined.

Decomposition:
- Shared package simon_pkg holds:
  - Colour codes: COL_GREEN=2'd0, COL_YELLOW=2'd1, COL_BLUE=2'd2, COL_RED=2'd3.
  - Code-to-one-hot function.
  - FSM state localparams SEQ_IDLE/SEQ_FILL/SEQ_DONE.
  - LFSR_MASK=16'hB400.
- One sub-module is natural: simon_lfsr16 (CLK, RESET, SEED parameter, 16-bit state out), free-running.
- Memory and FSM stay in simon_seq_store.

Test Plan:
- Reset values: assert RESET mid-cycle -> GEN_DONE=0, BUSY=0, COLOR_OH=0000 immediately; after release and one edge with RD_IDX=5 -> COLOR_OH=1000, COLOR_CODE=00.
- Fill timing: GEN_REQ pulsed one cycle at edge t -> BUSY=1 from t; GEN_DONE high only in cycle t+17; BUSY=0 from t+18.
- Fill contents: fill from SEED=16'hACE1 with GEN_REQ at a fixed cycle count after reset -> each index 0..15 reads back one cycle after RD_IDX is applied, matching a golden Galois model entry-for-entry.
- Request handling: GEN_REQ held high 40 cycles -> two back-to-back fills with GEN_DONE pulses 18 cycles apart; GEN_REQ pulses during FILL -> no extra GEN_DONE.
- Reset mid-fill: RESET at fill cycle 7 -> no GEN_DONE; all 16 entries read 00; a new GEN_REQ completes normally 17 cycles later.
- Feature on (SIMON_SEQ_NO_REPEAT_EN): force LFSR via SEED to produce an identical consecutive pair -> stored entries differ, with the second equal to (first+1) mod 4; across 100 fills, no adjacent pair is equal.
